// File: rtl/ysyx_22050499_wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter and its scoreboard.
// Register count, address width, zero-register index and producer ids.
package ysyx_22050499_wb_arbiter_pkg;

    localparam int NREG = 16;
    localparam int RA_W = 4;
    localparam logic [RA_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        PROD_ALU = 1'b0,
        PROD_LSU = 1'b1
    } prod_e;

endpackage

// File: rtl/ysyx_22050499_wb_scoreboard.sv
// Busy-register scoreboard: one pending-write bit per GPR.
// Set on issue, cleared on writeback; x0 is never busy.
module ysyx_22050499_wb_scoreboard
    import ysyx_22050499_wb_arbiter_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            set_en,
    input  logic [RA_W-1:0] set_rd,
    input  logic            clr_en,
    input  logic [RA_W-1:0] clr_rd,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic [RA_W-1:0] iss_rd,
    input  logic [RA_W-1:0] res_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            iss_busy,
    output logic            res_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next busy vector: clear the written register, set the issued one.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_rd] = 1'b0;
        if (set_en) busy_d[set_rd] = 1'b1;
        busy_d[REG_ZERO] = 1'b0;
        if (reset) busy_d = '0;
    end

    // Busy vector register.
    always_ff @(posedge clock) begin
        busy_q <= busy_d;
    end

    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];
    assign iss_busy = busy_q[iss_rd];
    assign res_busy = busy_q[res_rd];

endmodule

// File: rtl/ysyx_22050499_wb_arbiter.sv
// Writeback arbiter: picks one ALU/LSU result per cycle into a GPR write beat.
// Define WB_RR_ARB_EN for round-robin arbitration instead of fixed LSU priority.
module ysyx_22050499_wb_arbiter
    import ysyx_22050499_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [3:0]            issue_rd,
    output logic                  issue_ready,
    input  logic [3:0]            rs1,
    input  logic [3:0]            rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  alu_valid,
    input  logic [3:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [3:0]            lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    output logic                  wen,
    output logic [3:0]            waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  sb_err
);

    logic                  wen_q, wen_d;
    logic [RA_W-1:0]       waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  sb_err_q, sb_err_d;

    logic                  iss_busy;
    logic                  res_busy;
    logic                  set_en;
    logic                  fire;
    logic [RA_W-1:0]       res_rd;
    logic [DATA_WIDTH-1:0] res_data;

`ifdef WB_RR_ARB_EN
    prod_e last_grant_q, last_grant_d;
    logic  grant_lsu;
    logic  grant_alu;

    // Round-robin grant: on collision the producer not granted last time wins.
    always_comb begin
        grant_lsu    = lsu_valid && (!alu_valid || last_grant_q == PROD_ALU);
        grant_alu    = alu_valid && !grant_lsu;
        lsu_ready    = !reset && grant_lsu;
        alu_ready    = !reset && grant_alu;
        last_grant_d = last_grant_q;
        if (grant_lsu) last_grant_d = PROD_LSU;
        else if (grant_alu) last_grant_d = PROD_ALU;
        if (reset) last_grant_d = PROD_ALU;
    end

    // Last-grant register.
    always_ff @(posedge clock) begin
        last_grant_q <= last_grant_d;
    end
`else
    // Fixed priority: LSU always wins, ALU only when LSU is idle.
    always_comb begin
        lsu_ready = !reset;
        alu_ready = !reset && !lsu_valid;
    end
`endif

    // Select the consumed result and compute the next write beat.
    always_comb begin
        fire     = 1'b0;
        res_rd   = alu_rd;
        res_data = alu_data;
        if (lsu_valid && lsu_ready) begin
            fire     = 1'b1;
            res_rd   = lsu_rd;
            res_data = lsu_data;
        end else if (alu_valid && alu_ready) begin
            fire = 1'b1;
        end
        wen_d    = fire && res_rd != REG_ZERO;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        sb_err_d = sb_err_q || (wen_d && !res_busy);
        if (wen_d) begin
            waddr_d = res_rd;
            wdata_d = res_data;
        end
        if (reset) begin
            wen_d    = 1'b0;
            waddr_d  = '0;
            wdata_d  = '0;
            sb_err_d = 1'b0;
        end
    end

    // Write beat and sticky error registers.
    always_ff @(posedge clock) begin
        wen_q    <= wen_d;
        waddr_q  <= waddr_d;
        wdata_q  <= wdata_d;
        sb_err_q <= sb_err_d;
    end

    assign issue_ready = !reset && (issue_rd == REG_ZERO || !iss_busy);
    assign set_en      = issue_valid && issue_ready && issue_rd != REG_ZERO;

    ysyx_22050499_wb_scoreboard u_sb (
        .clock    (clock),
        .reset    (reset),
        .set_en   (set_en),
        .set_rd   (issue_rd),
        .clr_en   (wen_q),
        .clr_rd   (waddr_q),
        .rs1      (rs1),
        .rs2      (rs2),
        .iss_rd   (issue_rd),
        .res_rd   (res_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .iss_busy (iss_busy),
        .res_busy (res_busy)
    );

    assign wen    = wen_q;
    assign waddr  = waddr_q;
    assign wdata  = wdata_q;
    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_ysyx_22050499_wb_arbiter.sv
// Bench for ysyx_22050499_wb_arbiter: directed vectors, write beats
// checked by a monitor against a queue of expected {waddr, wdata}.
module tb_ysyx_22050499_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [3:0]  issue_rd;
    logic        issue_ready;
    logic [3:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [3:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        wen;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        sb_err;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];

    ysyx_22050499_wb_arbiter #(.DATA_WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .sb_err      (sb_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every write beat must match the oldest expected beat.
    always @(negedge clock) begin
        if (wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: waddr %h wdata %h", waddr, wdata);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                chk("wb_waddr", {28'h0, waddr}, {28'h0, e[35:32]});
                chk("wb_wdata", wdata, e[31:0]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        issue_valid = 1'b0; issue_rd = 4'd0;
        rs1 = 4'd5; rs2 = 4'd0;
        alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 32'h1234;
        lsu_valid = 1'b0; lsu_rd = 4'd0; lsu_data = 32'h0;

        // 1. reset held with a valid ALU result
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_alu_ready", {31'h0, alu_ready}, 32'h0);
            chk("rst_lsu_ready", {31'h0, lsu_ready}, 32'h0);
            chk("rst_issue_ready", {31'h0, issue_ready}, 32'h0);
            chk("rst_wen", {31'h0, wen}, 32'h0);
        end
        chk("rst_waddr", {28'h0, waddr}, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_sb_err", {31'h0, sb_err}, 32'h0);
        chk("rst_rs1_busy", {31'h0, rs1_busy}, 32'h0);
        reset = 1'b0; alu_valid = 1'b0;
        issue_rd = 4'd15; #1;
        chk("post_rst_issue_ready", {31'h0, issue_ready}, 32'h1);

        // 2. issue rd=5, ALU writes it back
        issue_valid = 1'b1; issue_rd = 4'd5;
        cyc();
        issue_valid = 1'b0; #1;
        chk("t2_rs1_busy_set", {31'h0, rs1_busy}, 32'h1);
        chk("t2_reissue_blocked", {31'h0, issue_ready}, 32'h0);
        alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 32'hDEADBEEF; #1;
        chk("t2_alu_ready", {31'h0, alu_ready}, 32'h1);
        exp_q.push_back({4'd5, 32'hDEADBEEF});
        cyc();
        alu_valid = 1'b0; #1;
        chk("t2_wen_beat", {31'h0, wen}, 32'h1);
        chk("t2_busy_during_wb", {31'h0, rs1_busy}, 32'h1);
        chk("t2_issue_blk_wb", {31'h0, issue_ready}, 32'h0);
        cyc();
        chk("t2_busy_cleared", {31'h0, rs1_busy}, 32'h0);
        chk("t2_reissue_ok", {31'h0, issue_ready}, 32'h1);
        chk("t2_wen_low", {31'h0, wen}, 32'h0);

        // 3. collision of ALU rd=3 and LSU rd=7
        issue_valid = 1'b1; issue_rd = 4'd3;
        cyc();
        issue_rd = 4'd7;
        cyc();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 4'd7; lsu_data = 32'h22; #1;
        chk("t3_alu_blocked", {31'h0, alu_ready}, 32'h0);
        chk("t3_lsu_ready", {31'h0, lsu_ready}, 32'h1);
        exp_q.push_back({4'd7, 32'h22});
        cyc();
        lsu_valid = 1'b0; #1;
        chk("t3_alu_ready2", {31'h0, alu_ready}, 32'h1);
        exp_q.push_back({4'd3, 32'h11});
        cyc();
        alu_valid = 1'b0;
        cyc();
        rs1 = 4'd3; rs2 = 4'd7; #1;
        chk("t3_rs1_clear", {31'h0, rs1_busy}, 32'h0);
        chk("t3_rs2_clear", {31'h0, rs2_busy}, 32'h0);

        // 4. ALU result to x0
        alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 32'hFFFFFFFF; #1;
        chk("t4_alu_ready", {31'h0, alu_ready}, 32'h1);
        cyc();
        alu_valid = 1'b0; #1;
        chk("t4_wen", {31'h0, wen}, 32'h0);
        chk("t4_sb_err", {31'h0, sb_err}, 32'h0);
        chk("t4_rs1_busy", {31'h0, rs1_busy}, 32'h0);

        // 5. LSU result without issue raises sticky error
        lsu_valid = 1'b1; lsu_rd = 4'd9; lsu_data = 32'h99;
        exp_q.push_back({4'd9, 32'h99});
        cyc();
        lsu_valid = 1'b0; #1;
        chk("t5_sb_err", {31'h0, sb_err}, 32'h1);
        cyc(); cyc();
        chk("t5_sb_err_sticky", {31'h0, sb_err}, 32'h1);

        // 6. set rd=4 and clear rd=2 in the same cycle
        issue_valid = 1'b1; issue_rd = 4'd2;
        cyc();
        issue_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 4'd2; lsu_data = 32'h2222;
        exp_q.push_back({4'd2, 32'h2222});
        cyc();
        lsu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 4'd4; #1;
        chk("t6_issue_ready", {31'h0, issue_ready}, 32'h1);
        cyc();
        issue_valid = 1'b0;
        rs1 = 4'd4; rs2 = 4'd2; #1;
        chk("t6_busy4", {31'h0, rs1_busy}, 32'h1);
        chk("t6_busy2", {31'h0, rs2_busy}, 32'h0);

        // reset while a result is being consumed
        alu_valid = 1'b1; alu_rd = 4'd4; alu_data = 32'h44;
        reset = 1'b1; #1;
        chk("t6_rst_alu_ready", {31'h0, alu_ready}, 32'h0);
        cyc();
        chk("t6_rst_wen", {31'h0, wen}, 32'h0);
        chk("t6_rst_busy4", {31'h0, rs1_busy}, 32'h0);
        chk("t6_rst_sb_err", {31'h0, sb_err}, 32'h0);
        reset = 1'b0; alu_valid = 1'b0;
        cyc(); cyc();

        chk("queue_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
